vga_sync_gen: RTL

Pixel-timing master for the VGA output path. It generates the PIXEL_H/PIXEL_V scan coordinates consumed by the text and tile renderers and samples their 3-bit PIXEL colour back. It drives HSYNC, VSYNC and RGB to the pins, with sync and blanking delayed to match renderer latency. One instance sits between the 50 MHz board clock and the VGA connector.

---
 rtl/vga_sync_gen_pkg.sv | 36 +++
 rtl/vga_sync_gen_pipe_delay.sv | 50 +++++
 rtl/vga_sync_gen.sv | 134 +++++++++++++
 3 files changed

// File: rtl/vga_sync_gen_pkg.sv
// vga_sync_gen_pkg
//   Shared VGA timing definitions for the sync generator and the text/tile
//   renderers: 640x480@60 default constants, coordinate and colour widths,
//   the packed timing-flag bundle carried through the latency pipe, and a
//   helper that derives line/frame totals from the four timing spans.
package vga_sync_gen_pkg;

    localparam int unsigned COORD_W = 11;
    localparam int unsigned COLOR_W = 3;

    localparam int unsigned DEF_H_VISIBLE = 640;
    localparam int unsigned DEF_H_FRONT   = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BACK    = 48;
    localparam int unsigned DEF_V_VISIBLE = 480;
    localparam int unsigned DEF_V_FRONT   = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BACK    = 33;

    // Raw decode results that must stay aligned with the renderer latency.
    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
    } timing_flags_t;

    localparam int unsigned FLAGS_W = $bits(timing_flags_t);

    function automatic int unsigned span_total(input int unsigned visible,
                                               input int unsigned front,
                                               input int unsigned sync,
                                               input int unsigned back);
        return visible + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_sync_gen_pipe_delay.sv
// vga_pipe_delay
//   DEPTH x WIDTH shift register that advances only when en is high.
//   All stages load RESET_VAL on a synchronous active-low reset.
//   DEPTH = 0 degenerates to a plain wire.
// Ports:
//   clk   in  1      clock
//   rst_n in  1      synchronous active-low reset
//   en    in  1      shift enable
//   din   in  WIDTH  data into stage 0
//   dout  out WIDTH  data out of the last stage
module vga_pipe_delay
    import vga_sync_gen_pkg::*;
#(
    parameter int unsigned       DEPTH     = 1,
    parameter int unsigned       WIDTH     = FLAGS_W,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, rst_n, en};
            assign dout = din;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        stage[i] <= RESET_VAL;
                    end
                end else if (en) begin
                    stage[0] <= din;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen
//   Pixel-timing master for the VGA output path. Divides clk into pixel
//   ticks, runs the horizontal/vertical scan counters, presents them to the
//   renderers, and drives sync plus blanked colour to the pins. Sync and
//   blanking are delayed by PIXEL_LAT ticks so they line up with the
//   renderer's colour; pins lag the coordinates by 1 + PIXEL_LAT ticks.
// Ports:
//   clk         in  1   system clock
//   rst_n       in  1   synchronous active-low reset
//   PIXEL       in  3   renderer colour {R,G,B} for the presented coordinate
//   PIXEL_H     out 11  horizontal count, 0..H_TOTAL-1
//   PIXEL_V     out 11  vertical count, 0..V_TOTAL-1
//   VGA_HS      out 1   horizontal sync (active level SYNC_POL)
//   VGA_VS      out 1   vertical sync (active level SYNC_POL)
//   VGA_RGB     out 3   blanked colour to the DAC
//   video_on    out 1   high while VGA_RGB shows a visible pixel
//   frame_start out 1   one-clk pulse when the counters wrap to (0,0)
module vga_sync_gen
    import vga_sync_gen_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
    parameter int unsigned H_FRONT   = DEF_H_FRONT,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BACK    = DEF_H_BACK,
    parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
    parameter int unsigned V_FRONT   = DEF_V_FRONT,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BACK    = DEF_V_BACK,
    parameter logic        SYNC_POL  = 1'b0,
    parameter int unsigned PIXEL_LAT = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COLOR_W-1:0] PIXEL,
    output logic [COORD_W-1:0] PIXEL_H,
    output logic [COORD_W-1:0] PIXEL_V,
    output logic               VGA_HS,
    output logic               VGA_VS,
    output logic [COLOR_W-1:0] VGA_RGB,
    output logic               video_on,
    output logic               frame_start
);

    localparam int unsigned H_TOTAL = span_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL = span_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);

    // Sync windows kept as 32-bit bounds so a window ending at 2048 cannot wrap.
    localparam int unsigned H_SYNC_FIRST = H_VISIBLE + H_FRONT;
    localparam int unsigned H_SYNC_LAST  = H_SYNC_FIRST + H_SYNC - 1;
    localparam int unsigned V_SYNC_FIRST = V_VISIBLE + V_FRONT;
    localparam int unsigned V_SYNC_LAST  = V_SYNC_FIRST + V_SYNC - 1;

    localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);

    logic [1:0]         div_cnt;
    logic               pix_en;
    logic [COORD_W-1:0] h_cnt;
    logic [COORD_W-1:0] v_cnt;
    timing_flags_t      raw_flags;
    timing_flags_t      dly_flags;

    // With CLK_DIV = 1 div_cnt stays at 0 = DIV_LAST, so pix_en is constant high.
    assign pix_en = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (pix_en) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_en && (h_cnt == H_LAST) && (v_cnt == V_LAST);
            if (pix_en) begin
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end
        end
    end

    assign PIXEL_H = h_cnt;
    assign PIXEL_V = v_cnt;

    always_comb begin
        raw_flags     = '0;
        raw_flags.act = (32'(h_cnt) < H_VISIBLE) && (32'(v_cnt) < V_VISIBLE);
        raw_flags.hs  = (32'(h_cnt) >= H_SYNC_FIRST) && (32'(h_cnt) <= H_SYNC_LAST);
        raw_flags.vs  = (32'(v_cnt) >= V_SYNC_FIRST) && (32'(v_cnt) <= V_SYNC_LAST);
    end

    // Aligns blanking/sync with colour arriving PIXEL_LAT ticks late.
    vga_pipe_delay #(
        .DEPTH     (PIXEL_LAT),
        .WIDTH     (FLAGS_W),
        .RESET_VAL ('0)
    ) u_flag_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pix_en),
        .din   (raw_flags),
        .dout  (dly_flags)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            VGA_RGB  <= '0;
            video_on <= 1'b0;
            VGA_HS   <= ~SYNC_POL;
            VGA_VS   <= ~SYNC_POL;
        end else if (pix_en) begin
            VGA_RGB  <= dly_flags.act ? PIXEL : '0;
            video_on <= dly_flags.act;
            VGA_HS   <= dly_flags.hs ? SYNC_POL : ~SYNC_POL;
            VGA_VS   <= dly_flags.vs ? SYNC_POL : ~SYNC_POL;
        end
    end

endmodule
